// File: rtl/multi_channel_burst_engine.sv
// Multi-channel photon pulse engine: per-channel synchroniser, interval timer, pulse counter,
// sliding-window burst detector and latched result, with a registered readout port.
module multi_channel_burst_engine #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int MAX_N  = 32,
  parameter int N_W    = $clog2(MAX_N + 1),
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [NUM_CH-1:0] pulse_in,
  input  logic              stop_count,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [WIDTH-1:0]  cfg_data,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [1:0]        rd_field,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic [NUM_CH-1:0] burst_detected,
  output logic              burst_any
);
  localparam int SUM_W = WIDTH + N_W;
  localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [WIDTH-1:0] SAT = '1;
  localparam logic [N_W-1:0] N_MAX = N_W'(MAX_N);

  logic [N_W-1:0]    n_reg;
  logic [WIDTH-1:0]  thr_reg;
  logic              mode_reg;
  logic [NUM_CH-1:0] mask_reg;
  logic [N_W-1:0]    n_wr;
  logic              win_clr;
  logic              stop_q_reg;
  logic              snap;
  logic [NUM_CH-1:0] s0_reg, s1_reg, s2_reg, edge_reg;

  logic [WIDTH-1:0] lat_arr  [NUM_CH];
  logic [WIDTH-1:0] pcnt_arr [NUM_CH];
  logic [WIDTH-1:0] sum_arr  [NUM_CH];
  logic [WIDTH-1:0] bcnt_arr [NUM_CH];
  logic [WIDTH-1:0] rd_mux;

  // Window length is clamped into 1..MAX_N so the window is never empty or oversized.
  always_comb begin
    n_wr = cfg_data[N_W-1:0];
    if (cfg_data == '0)
      n_wr = N_W'(1);
    else if (cfg_data > WIDTH'(MAX_N))
      n_wr = N_MAX;
  end

  assign win_clr = cfg_we && (cfg_addr == 2'd0);
  assign snap    = stop_count && !stop_q_reg && mode_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      n_reg      <= N_MAX;
      thr_reg    <= '0;
      mode_reg   <= 1'b0;
      mask_reg   <= '1;
      stop_q_reg <= 1'b0;
      s0_reg     <= '0;
      s1_reg     <= '0;
      s2_reg     <= '0;
      edge_reg   <= '0;
    end else begin
      stop_q_reg <= stop_count;
      s0_reg     <= pulse_in;
      s1_reg     <= s0_reg;
      s2_reg     <= s1_reg;
      edge_reg   <= s1_reg & ~s2_reg & mask_reg;
      if (cfg_we) begin
        case (cfg_addr)
          2'd0:    n_reg    <= n_wr;
          2'd1:    thr_reg  <= cfg_data;
          2'd2:    mode_reg <= cfg_data[0];
          default: mask_reg <= cfg_data[NUM_CH-1:0];
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] ic_reg, pcnt_reg, lat_reg, bcnt_reg;
      logic             armed_reg, push_d_reg, burst_reg;
      logic [N_W-1:0]   fill_reg;
      logic [SUM_W-1:0] sum_reg;
      logic [WIDTH-1:0] tap_reg [MAX_N];
      logic [WIDTH-1:0] ic_inc, oldest;
      logic [IDX_W-1:0] old_idx;
      logic             push, full, burst_next;

      assign ic_inc     = (ic_reg == SAT) ? SAT : ic_reg + 1'b1;
      assign push       = edge_reg[gi] && armed_reg;
      assign full       = (fill_reg == n_reg);
      assign old_idx    = IDX_W'(n_reg - 1'b1);
      assign oldest     = full ? tap_reg[old_idx] : '0;
      assign burst_next = full && (sum_reg <= SUM_W'(thr_reg));

      always_ff @(posedge clock) begin
        if (reset) begin
          ic_reg     <= '0;
          pcnt_reg   <= '0;
          lat_reg    <= '0;
          bcnt_reg   <= '0;
          armed_reg  <= 1'b0;
          push_d_reg <= 1'b0;
          burst_reg  <= 1'b0;
          fill_reg   <= '0;
          sum_reg    <= '0;
        end else begin
          // Snapshot reads the count before any coincident edge increments it.
          if (snap)
            lat_reg <= pcnt_reg;
          if (!run) begin
            ic_reg     <= '0;
            pcnt_reg   <= '0;
            bcnt_reg   <= '0;
            armed_reg  <= 1'b0;
            push_d_reg <= 1'b0;
            burst_reg  <= 1'b0;
            fill_reg   <= '0;
            sum_reg    <= '0;
          end else begin
            push_d_reg <= push && !win_clr;
            if (edge_reg[gi]) begin
              ic_reg    <= '0;
              armed_reg <= 1'b1;
              if (pcnt_reg != SAT)
                pcnt_reg <= pcnt_reg + 1'b1;
            end else begin
              ic_reg <= ic_inc;
            end
            if (win_clr) begin
              fill_reg  <= '0;
              sum_reg   <= '0;
              burst_reg <= 1'b0;
            end else begin
              if (push) begin
                sum_reg  <= sum_reg + SUM_W'(ic_inc) - SUM_W'(oldest);
                fill_reg <= full ? fill_reg : fill_reg + 1'b1;
              end
              if (push_d_reg) begin
                burst_reg <= burst_next;
                if (burst_next && !burst_reg && bcnt_reg != SAT)
                  bcnt_reg <= bcnt_reg + 1'b1;
              end
            end
            if (push && !mode_reg)
              lat_reg <= ic_inc;
          end
        end
      end

      // Taps are qualified by fill_reg, so stale contents never need clearing.
      always_ff @(posedge clock) begin
        if (!reset && run && push) begin
          tap_reg[0] <= ic_inc;
          for (int i = 1; i < MAX_N; i++)
            tap_reg[i] <= tap_reg[i-1];
        end
      end

      assign lat_arr[gi]        = lat_reg;
      assign pcnt_arr[gi]       = pcnt_reg;
      assign bcnt_arr[gi]       = bcnt_reg;
      assign sum_arr[gi]        = (sum_reg > SUM_W'(SAT)) ? SAT : sum_reg[WIDTH-1:0];
      assign burst_detected[gi] = burst_reg;
    end
  endgenerate

  assign burst_any = |burst_detected;

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) begin
        case (rd_field)
          2'd0:    rd_mux = lat_arr[c];
          2'd1:    rd_mux = pcnt_arr[c];
          2'd2:    rd_mux = sum_arr[c];
          default: rd_mux = bcnt_arr[c];
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= rd_mux;
    end
  end
endmodule

// File: tb/tb_multi_channel_burst_engine.sv
// Directed bench for multi_channel_burst_engine: 4 channels, 8-bit data, 3-bit channel select.
module tb_multi_channel_burst_engine;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int MAX_N  = 32;
  localparam int CH_W   = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              run = 1'b0;
  logic [NUM_CH-1:0] pulse_in = '0;
  logic              stop_count = 1'b0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_addr = '0;
  logic [WIDTH-1:0]  cfg_data = '0;
  logic              rd_en = 1'b0;
  logic [CH_W-1:0]   rd_ch = '0;
  logic [1:0]        rd_field = '0;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic [NUM_CH-1:0] burst_detected;
  logic              burst_any;

  int total = 0;
  int bad = 0;

  multi_channel_burst_engine #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .MAX_N(MAX_N), .CH_W(CH_W)
  ) dut (
    .clock(clock), .reset(reset), .run(run), .pulse_in(pulse_in),
    .stop_count(stop_count), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_field(rd_field), .rd_data(rd_data),
    .rd_valid(rd_valid), .burst_detected(burst_detected), .burst_any(burst_any)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cfg(input logic [1:0] a, input logic [WIDTH-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd_check(input string tag, input int ch, input int f, input int exp);
    rd_en = 1'b1; rd_ch = CH_W'(ch); rd_field = 2'(f);
    tick();
    rd_en = 1'b0;
    check({tag, "_data"}, 32'(rd_data), 32'(exp));
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
  endtask

  task automatic pulse_wait(input int ch, input int period);
    pulse_in[ch] = 1'b1;
    tick();
    pulse_in[ch] = 1'b0;
    repeat (period - 1) tick();
  endtask

  task automatic run_restart();
    run = 1'b0;
    tick();
    run = 1'b1;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_burst", 32'(burst_detected), 32'd0);
    check("rst_any", 32'(burst_any), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);

    // Period 10, n=4, threshold 40: window fills on the 5th pulse with sum 40
    cfg(2'd0, 8'd4);
    cfg(2'd1, 8'd40);
    run = 1'b1;
    repeat (4) pulse_wait(0, 10);
    check("t1_no_burst_yet", 32'(burst_detected), 32'd0);
    pulse_wait(0, 10);
    check("t1_burst", 32'(burst_detected), 32'b0001);
    check("t1_any", 32'(burst_any), 32'd1);
    rd_check("t1_sum", 0, 2, 40);
    tick();
    check("t1_valid_one_cycle", 32'(rd_valid), 32'd0);
    rd_check("t1_interval", 0, 0, 10);
    rd_check("t1_pcount", 0, 1, 5);
    rd_check("t1_bcount", 0, 3, 1);

    // Period 11: sum 44 exceeds threshold
    run_restart();
    repeat (5) pulse_wait(0, 11);
    check("t2_burst", 32'(burst_detected), 32'd0);
    rd_check("t2_sum", 0, 2, 44);
    rd_check("t2_interval", 0, 0, 11);
    rd_check("t2_bcount", 0, 3, 0);

    // Count mode snapshot on ch2
    cfg(2'd2, 8'd1);
    run_restart();
    repeat (7) pulse_wait(2, 5);
    stop_count = 1'b1;
    tick();
    stop_count = 1'b0;
    rd_check("t3_snap7", 2, 0, 7);
    // 8th pulse strobes on the same edge as the snapshot
    pulse_in[2] = 1'b1;
    tick();
    pulse_in[2] = 1'b0;
    repeat (2) tick();
    stop_count = 1'b1;
    tick();
    stop_count = 1'b0;
    repeat (2) tick();
    rd_check("t3_snap_coincident", 2, 0, 7);
    rd_check("t3_pcount8", 2, 1, 8);

    // Masking and window length clamp
    cfg(2'd2, 8'd0);
    cfg(2'd3, 8'h0e);
    run_restart();
    repeat (3) pulse_wait(0, 10);
    rd_check("t4_masked_pcount", 0, 1, 0);
    repeat (5) pulse_wait(1, 10);
    check("t4_ch1_burst", 32'(burst_detected), 32'b0010);
    cfg(2'd0, 8'd0);
    check("t4_clear_burst", 32'(burst_detected), 32'd0);
    check("t4_clear_any", 32'(burst_any), 32'd0);
    rd_check("t4_clear_sum", 1, 2, 0);
    repeat (2) pulse_wait(1, 10);
    rd_check("t4_n1_sum", 1, 2, 10);
    check("t4_n1_burst", 32'(burst_detected), 32'b0010);

    // 8-bit saturation of interval and pulse count on ch3
    run_restart();
    pulse_wait(3, 2);
    repeat (300) tick();
    pulse_wait(3, 5);
    rd_check("t5_interval_sat", 3, 0, 255);
    repeat (300) pulse_wait(3, 2);
    repeat (5) tick();
    rd_check("t5_pcount_sat", 3, 1, 255);
    rd_check("t5_sum", 3, 2, 2);
    rd_check("t5_bcount", 3, 3, 1);
    check("t5_burst", 32'(burst_detected), 32'b1000);

    // Reset mid-burst
    cfg(2'd2, 8'd1);
    rd_check("t6_pre_reset", 3, 1, 255);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_burst", 32'(burst_detected), 32'd0);
    check("t6_any", 32'(burst_any), 32'd0);
    check("t6_rd_data", 32'(rd_data), 32'd0);
    check("t6_rd_valid", 32'(rd_valid), 32'd0);
    repeat (2) pulse_wait(0, 10);
    check("t6_no_burst", 32'(burst_detected), 32'd0);
    rd_check("t6_mask_default", 0, 1, 2);
    rd_check("t6_mode_default", 0, 0, 10);
    rd_check("t6_bad_channel", 5, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
